// File: rtl/controle_bloco.sv
// -----------------------------------------------------------------------------
// controle_bloco
//
// Sequencer for the BLOCO datapath (4 x 16-bit register file + ALU with flags).
// Fetches 16-bit words from a synchronous program ROM, decodes each word into
// BLOCO's control inputs and steps through the program from address 0 on a
// start request until HALT, then pulses done.
//
// Instruction word:
//   ALU class     (bit15=0): [14:10] op, [9:8] SC, [7:6] SA, [5:4] SB, [3] we
//   control class (bit15=1): [14:13] ctl (00 HALT, 01 JMP, 10 JZ, 11 NOP),
//                            [7:0] target address
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   start               run request, honoured only in IDLE
//   instr_data          ROM read data, valid the cycle after instr_addr
//   flag_zero           zero flag from BLOCO, used by JZ
//   instr_addr          ROM address (pc while running, 0 in IDLE)
//   Hab_Escrita         register file write enable
//   Sel_SA/Sel_SB       operand A/B register selects
//   Sel_SC              destination register select
//   controleOperacao    ALU operation
//   reset_Ban_Registros register file clear pulse (active high)
//   reset_Flags         flag clear pulse (active high)
//   busy                high in every state except IDLE
//   done                one-cycle pulse when HALT completes
// -----------------------------------------------------------------------------
module controle_bloco #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2,
  parameter int bits_op       = 5,
  parameter int bits_pc       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [bits_palavra-1:0]  instr_data,
  input  logic                     flag_zero,
  output logic [bits_pc-1:0]       instr_addr,
  output logic                     Hab_Escrita,
  output logic [end_registros-1:0] Sel_SA,
  output logic [end_registros-1:0] Sel_SB,
  output logic [end_registros-1:0] Sel_SC,
  output logic [bits_op-1:0]       controleOperacao,
  output logic                     reset_Ban_Registros,
  output logic                     reset_Flags,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CTL_HALT = 2'b00,
    CTL_JMP  = 2'b01,
    CTL_JZ   = 2'b10,
    CTL_NOP  = 2'b11
  } ctl_t;

  state_t                  state;
  logic [bits_pc-1:0]      pc;
  logic [bits_palavra-1:0] ir;

  // Decoded views of the instruction register.
  logic               ir_is_ctl;
  ctl_t               ir_ctl;
  logic               ir_we;
  logic [bits_pc-1:0] ir_target;
  logic [bits_pc-1:0] pc_inc;

  assign ir_is_ctl = ir[15];
  assign ir_ctl    = ctl_t'(ir[14:13]);
  assign ir_we     = ir[3];
  assign ir_target = ir[bits_pc-1:0];
  assign pc_inc    = pc + bits_pc'(1);   // wraps modulo 2^bits_pc

  // Bits of the word that carry no meaning for the sequencer.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[12:8], ir[2:0]};

  // NOTE: every output is a flop loaded on the transition into the state that
  // owns it, so each output value is exactly "what this state drives" with no
  // combinational decode glitches toward BLOCO. Pulses are defaulted low at the
  // top of the clocked branch and only raised on the entering transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments throughout this block; every register
      // here (state, pc, ir and the outputs) is cleared by the async reset.
      state               <= S_IDLE;
      pc                  <= '0;
      ir                  <= '0;
      instr_addr          <= '0;
      Hab_Escrita         <= 1'b0;
      Sel_SA              <= '0;
      Sel_SB              <= '0;
      Sel_SC              <= '0;
      controleOperacao    <= '0;
      reset_Ban_Registros <= 1'b0;
      reset_Flags         <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      Hab_Escrita         <= 1'b0;
      reset_Ban_Registros <= 1'b0;
      reset_Flags         <= 1'b0;
      done                <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state               <= S_CLEAR;
            busy                <= 1'b1;
            reset_Ban_Registros <= 1'b1;
            reset_Flags         <= 1'b1;
            instr_addr          <= pc;
          end
        end

        S_CLEAR: begin
          pc         <= '0;
          instr_addr <= '0;
          state      <= S_FETCH;
        end

        S_FETCH: begin
          state <= S_DECODE;
        end

        S_DECODE: begin
          ir    <= instr_data;
          state <= S_EXEC;
          // Operand selects and op are launched here so they are already
          // stable during EXEC, a full cycle before the write strobe.
          if (!instr_data[15]) begin
            controleOperacao <= instr_data[14:10];
            Sel_SC           <= instr_data[9:8];
            Sel_SA           <= instr_data[7:6];
            Sel_SB           <= instr_data[5:4];
          end
        end

        S_EXEC: begin
          if (!ir_is_ctl) begin
            Hab_Escrita <= ir_we;
            state       <= S_WRITE;
          end else begin
            case (ir_ctl)
              CTL_HALT: begin
                done  <= 1'b1;
                state <= S_DONE;
              end
              CTL_JMP: begin
                pc         <= ir_target;
                instr_addr <= ir_target;
                state      <= S_FETCH;
              end
              CTL_JZ: begin
                pc         <= flag_zero ? ir_target : pc_inc;
                instr_addr <= flag_zero ? ir_target : pc_inc;
                state      <= S_FETCH;
              end
              default: begin  // CTL_NOP
                pc         <= pc_inc;
                instr_addr <= pc_inc;
                state      <= S_FETCH;
              end
            endcase
          end
        end

        S_WRITE: begin
          pc               <= pc_inc;
          instr_addr       <= pc_inc;
          controleOperacao <= '0;
          Sel_SA           <= '0;
          Sel_SB           <= '0;
          Sel_SC           <= '0;
          state            <= S_FETCH;
        end

        S_DONE: begin
          busy       <= 1'b0;
          instr_addr <= '0;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_bloco.sv
// -----------------------------------------------------------------------------
// tb_controle_bloco
//
// Self-checking bench for controle_bloco. A synchronous ROM model feeds the
// DUT; an instruction-level reference model walks the same ROM using the
// instruction timing rules (CLEAR, then 4 cycles per ALU word and 3 per
// control word) to predict fetch addresses, decoded fields, write strobes and
// the done cycle. Per-cycle DUT outputs are captured and compared afterwards.
// -----------------------------------------------------------------------------
module tb_controle_bloco;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] instr_data;
  logic        flag_zero;
  logic [7:0]  instr_addr;
  logic        Hab_Escrita;
  logic [1:0]  Sel_SA, Sel_SB, Sel_SC;
  logic [4:0]  controleOperacao;
  logic        reset_Ban_Registros, reset_Flags, busy, done;

  controle_bloco dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .instr_data          (instr_data),
    .flag_zero           (flag_zero),
    .instr_addr          (instr_addr),
    .Hab_Escrita         (Hab_Escrita),
    .Sel_SA              (Sel_SA),
    .Sel_SB              (Sel_SB),
    .Sel_SC              (Sel_SC),
    .controleOperacao    (controleOperacao),
    .reset_Ban_Registros (reset_Ban_Registros),
    .reset_Flags         (reset_Flags),
    .busy                (busy),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM.
  logic [15:0] rom [0:255];
  always @(posedge clk) instr_data <= rom[instr_addr];

  typedef struct packed {
    logic [7:0] addr;
    logic       hab;
    logic [1:0] sa, sb, sc;
    logic [4:0] op;
    logic       rbr, rf, busy, done;
  } samp_t;

  samp_t samp [0:1023];

  // Reference model results.
  logic [7:0]  exp_pc [0:511];
  logic [15:0] exp_w  [0:511];
  int          exp_t  [0:511];
  int          n_exp;
  int          t_done;

  int compared   = 0;
  int mismatched = 0;

  function automatic samp_t snap();
    samp_t s;
    s.addr = instr_addr;  s.hab = Hab_Escrita;
    s.sa   = Sel_SA;      s.sb  = Sel_SB;      s.sc = Sel_SC;
    s.op   = controleOperacao;
    s.rbr  = reset_Ban_Registros;  s.rf = reset_Flags;
    s.busy = busy;        s.done = done;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int a = 0; a < 256; a++) rom[a] = w;
  endtask

  // Instruction-level model: first JZ executed sees f_first, later ones f_rest.
  task automatic model(input bit f_first, input bit f_rest);
    logic [7:0]  pc;
    logic [15:0] w;
    int          t;
    bit          first_jz, halted;
    pc = 8'd0; t = 2; first_jz = 1'b1; halted = 1'b0; n_exp = 0; t_done = 0;
    while (!halted && n_exp < 500) begin
      w = rom[pc];
      exp_pc[n_exp] = pc; exp_t[n_exp] = t; exp_w[n_exp] = w;
      n_exp++;
      if (!w[15]) begin
        pc = pc + 8'd1;
        t += 4;
      end else begin
        case (w[14:13])
          2'b00: begin halted = 1'b1; t_done = t + 3; end
          2'b01: pc = w[7:0];
          2'b10: begin
            if (first_jz ? f_first : f_rest) pc = w[7:0];
            else                             pc = pc + 8'd1;
            first_jz = 1'b0;
          end
          default: pc = pc + 8'd1;
        endcase
        t += 3;
      end
    end
  endtask

  // Pulse/hold start, then capture ncyc cycles (index 1 = cycle after the
  // IDLE sample edge). Optional start pulse mid-run and flag drop on address.
  task automatic run(input int ncyc, input bit hold, input int mid_start,
                     input bit use_drop, input logic [7:0] drop_addr);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = hold;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      samp[n] = snap();
      if (n == mid_start) start = 1'b1;
      else                start = hold;
      if (use_drop && samp[n].addr == drop_addr) flag_zero = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input bit hold);
    int t, hab_cnt, we_cnt, busy_cnt;
    logic [15:0] w;
    we_cnt = 0;
    check({name, ".clear"}, 32'({samp[1].rbr, samp[1].rf, samp[1].busy}), 32'(3'b111));
    for (int i = 0; i < n_exp; i++) begin
      t = exp_t[i]; w = exp_w[i];
      check($sformatf("%s.fetch[%0d]", name, i), 32'(samp[t].addr), 32'(exp_pc[i]));
      if (!w[15]) begin
        if (w[3]) we_cnt++;
        check($sformatf("%s.exec_fields[%0d]", name, i),
              32'({samp[t+2].op, samp[t+2].sc, samp[t+2].sa, samp[t+2].sb}),
              32'({w[14:10], w[9:8], w[7:6], w[5:4]}));
        check($sformatf("%s.exec_we[%0d]", name, i), 32'(samp[t+2].hab), 32'(0));
        check($sformatf("%s.write_fields[%0d]", name, i),
              32'({samp[t+3].op, samp[t+3].sc, samp[t+3].sa, samp[t+3].sb}),
              32'({w[14:10], w[9:8], w[7:6], w[5:4]}));
        check($sformatf("%s.write_we[%0d]", name, i), 32'(samp[t+3].hab), 32'(w[3]));
      end else begin
        check($sformatf("%s.ctl_exec_quiet[%0d]", name, i),
              32'({samp[t+2].hab, samp[t+2].op, samp[t+2].sc, samp[t+2].sa, samp[t+2].sb}),
              32'(0));
      end
    end
    check({name, ".pre_done"}, 32'(samp[t_done-1].done), 32'(0));
    check({name, ".done"}, 32'({samp[t_done].busy, samp[t_done].done}), 32'(2'b11));
    check({name, ".idle_after"},
          32'({samp[t_done+1].addr, samp[t_done+1].busy, samp[t_done+1].done}), 32'(0));
    if (hold)
      check({name, ".restart_clear"},
            32'({samp[t_done+2].rbr, samp[t_done+2].rf, samp[t_done+2].busy}), 32'(3'b111));
    hab_cnt = 0; busy_cnt = 0;
    for (int n = 1; n <= t_done + 1; n++) begin
      hab_cnt  += int'(samp[n].hab);
      busy_cnt += int'(samp[n].busy);
    end
    check({name, ".we_cycles"}, 32'(hab_cnt), 32'(we_cnt));
    check({name, ".busy_cycles"}, 32'(busy_cnt), 32'(t_done));
  endtask

  task automatic do_run(input string name, input bit f_first, input bit f_rest,
                        input bit hold, input int mid_start, input bit use_drop,
                        input logic [7:0] drop_addr);
    flag_zero = f_first;
    model(f_first, f_rest);
    run(t_done + 3, hold, mid_start, use_drop, drop_addr);
    check_run(name, hold);
  endtask

  task automatic gen_random(output bit flag);
    int          len, k, tgt;
    logic [31:0] r;
    fill_rom(16'h8000);
    len = int'($urandom_range(4, 10));
    for (int a = 0; a < len; a++) begin
      k = int'($urandom_range(0, 3));
      r = $urandom;
      case (k)
        0, 1: rom[a] = {1'b0, r[14:0]};
        2:    rom[a] = {3'b111, r[12:0]};
        default: begin
          tgt = a + 1 + int'($urandom_range(0, len - a - 1));
          rom[a] = {1'b1, (r[15] ? 2'b10 : 2'b01), r[12:8], 8'(tgt)};
        end
      endcase
    end
    r = $urandom;
    flag = r[0];
  endtask

  initial begin
    bit f;
    start = 1'b0; flag_zero = 1'b0; reset = 1'b1;
    fill_rom(16'h8000);
    #3 reset = 1'b0;
    #10;
    check("reset_outputs", 32'(snap()), 32'(0));
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_start", 32'(snap()), 32'(0));

    // Basic ALU write then HALT.
    fill_rom(16'h8000);
    rom[0] = 16'h0618; rom[1] = 16'h8000;
    do_run("alu_we", 1'b0, 1'b0, 1'b0, -1, 1'b0, 8'h00);
    check("alu_we.latency", 32'(t_done), 32'(9));

    // Reset while WRITE is strobing: everything drops at once, stays IDLE.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort.write_strobe", 32'(Hab_Escrita), 32'(1));
    #2 reset = 1'b0;
    #1 check("abort.async_clear", 32'(snap()), 32'(0));
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    check("abort.stays_idle", 32'(snap()), 32'(0));

    // we=0: selects driven, no write strobe.
    rom[0] = 16'h0610;
    do_run("alu_no_we", 1'b0, 1'b0, 1'b0, -1, 1'b0, 8'h00);

    // JMP skips addresses 1-4.
    fill_rom(16'h8000);
    rom[0] = 16'hA005; rom[1] = 16'h0418; rom[5] = 16'h8000;
    do_run("jmp", 1'b0, 1'b0, 1'b0, -1, 1'b0, 8'h00);

    // JZ taken and not taken.
    fill_rom(16'h8000);
    rom[0] = 16'hC010; rom[1] = 16'hE000; rom[2] = 16'h8000; rom[16] = 16'h8000;
    do_run("jz_taken", 1'b1, 1'b1, 1'b0, -1, 1'b0, 8'h00);
    do_run("jz_not_taken", 1'b0, 1'b0, 1'b0, -1, 1'b0, 8'h00);

    // pc wrap FF -> 00 through a NOP field, with an ignored start while busy.
    fill_rom(16'hE000);
    rom[0] = 16'hC0FE; rom[1] = 16'h8000;
    do_run("wrap", 1'b1, 1'b0, 1'b0, 6, 1'b1, 8'hFE);

    // start held through DONE: a new run begins from IDLE.
    fill_rom(16'h8000);
    rom[0] = 16'h1D28;
    do_run("hold_start", 1'b0, 1'b0, 1'b1, -1, 1'b0, 8'h00);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("hold_start.reset_abort", 32'(snap()), 32'(0));

    // Randomized forward-only programs.
    for (int r = 0; r < 4; r++) begin
      gen_random(f);
      do_run($sformatf("rand%0d", r), f, f, 1'b0, -1, 1'b0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
